// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction memory loader. It consumes a byte stream made of a
// 16-bit word count L (high byte first) followed by L big-endian 4-byte words,
// and writes each completed word into instruction memory at byte address
// word_index*4. The CPU is held in reset until the whole program is written.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset (0 = reset)
//   in_valid   byte stream valid
//   in_data    byte stream data
//   in_ready   loader accepts a byte this cycle
//   mem_we     instruction memory write strobe (one cycle per word)
//   mem_addr   byte address of the write (word_index * 4)
//   mem_wdata  instruction word to write
//   cpu_hold   holds the CPU in reset while 1
//   done       program loaded, CPU released
//   error      declared length exceeds DEPTH
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    localparam logic [2:0] LEN_HI = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] ERROR  = 3'd5;

    // DEPTH widened by one bit so a DEPTH of 65536 still compares correctly.
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    logic [2:0]  state;
    logic [15:0] len;
    logic [15:0] word_index;
    logic [1:0]  byte_cnt;
    logic [31:0] asm_word;
    // Keeps in_ready low for the first cycle after reset is released.
    logic        armed;

    logic        accept;
    logic [15:0] len_full;
    logic [31:0] word_full;

    assign accept    = in_valid & in_ready;
    assign len_full  = {len[15:8], in_data};
    assign word_full = {asm_word[23:0], in_data};

    assign in_ready = armed && ((state == LEN_HI) || (state == LEN_LO) || (state == DATA));
    assign cpu_hold = (state != DONE);
    assign done     = (state == DONE);
    assign error    = (state == ERROR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= LEN_HI;
            len        <= '0;
            word_index <= '0;
            byte_cnt   <= '0;
            asm_word   <= '0;
            armed      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            armed  <= 1'b1;
            mem_we <= 1'b0;
            case (state)
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= in_data;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= in_data;
                        if (len_full == 16'd0)
                            state <= DONE;
                        else if ({1'b0, len_full} > DEPTH_L)
                            state <= ERROR;
                        else
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        asm_word <= word_full;
                        byte_cnt <= byte_cnt + 2'd1;
                        // The write port is loaded here so the strobe, address
                        // and data are all valid exactly during WRITE and the
                        // address/data then hold until the next word.
                        if (byte_cnt == 2'd3) begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= {14'd0, word_index, 2'b00};
                            mem_wdata <= WIDTH'(word_full);
                        end
                    end
                end
                WRITE: begin
                    word_index <= word_index + 16'd1;
                    if ((word_index + 16'd1) == len)
                        state <= DONE;
                    else
                        state <= DATA;
                end
                DONE, ERROR: begin
                    state <= state;
                end
                default: begin
                    state <= LEN_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. A stream-level reference model (counts
// of accepted bytes and completed words) predicts every output each cycle;
// directed streams with literal expectations pin the model, then randomized
// streams with random valid gaps and mid-load resets exercise the rest.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             cpu_hold;
    logic             done;
    logic             error;

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (stream level) ----------------
    bit          chk_en = 1'b0;
    bit          m_armed;
    int          m_n;      // bytes accepted since reset
    int          m_nw;     // words fully written
    int          m_L;
    bit          m_wr;     // a write strobe is expected this cycle
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [31:0] m_acc;
    int          m_accn;

    function automatic bit m_done();
        return (m_n >= 2) && (m_L <= DEPTH) && (m_nw == m_L);
    endfunction

    function automatic bit m_err();
        return (m_n >= 2) && (m_L > DEPTH);
    endfunction

    function automatic bit m_ready();
        return m_armed && !m_wr && !m_done() && !m_err();
    endfunction

    always @(posedge clk) begin
        bit rdy;
        if (!reset) begin
            chk_en  = 1'b1;
            m_armed = 1'b0;
            m_n     = 0;
            m_nw    = 0;
            m_L     = 0;
            m_wr    = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            m_acc   = '0;
            m_accn  = 0;
        end else if (chk_en) begin
            rdy     = m_ready();
            m_armed = 1'b1;
            if (m_wr) begin
                m_wr = 1'b0;
                m_nw++;
            end
            if (rdy && in_valid) begin
                m_n++;
                if (m_n == 1) begin
                    m_L = int'(in_data) * 256;
                end else if (m_n == 2) begin
                    m_L = m_L + int'(in_data);
                end else begin
                    m_acc = {m_acc[23:0], in_data};
                    m_accn++;
                    if (m_accn == 4) begin
                        m_accn = 0;
                        m_wr   = 1'b1;
                        m_addr = 32'(m_nw * 4);
                        m_data = m_acc;
                    end
                end
            end
        end
    end

    // Log of DUT writes, used by the literal expectations.
    logic [63:0] wlog[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  64'(in_ready),  64'(m_ready()));
            chk("mem_we",    64'(mem_we),    64'(m_wr));
            chk("mem_addr",  64'(mem_addr),  64'(m_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_data));
            chk("done",      64'(done),      64'(m_done()));
            chk("error",     64'(error),     64'(m_err()));
            chk("cpu_hold",  64'(cpu_hold),  64'(!m_done()));
            if (mem_we === 1'b1) wlog.push_back({mem_addr, 32'(mem_wdata)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wlog.delete();
    endtask

    // pv: valid probability in percent, or -1 for strict 1/0 toggling.
    // abort_after: stop once this many bytes were accepted (-1 = never).
    task automatic send(input logic [7:0] q[$], input int pv, input int abort_after,
                        input bit must_finish, input string nm);
        int i      = 0;
        int cyc    = 0;
        int stall  = 0;
        bit tog    = 1'b1;
        bit r;
        bit v;
        while (i < q.size() && cyc < 4000 && stall < 8) begin
            if (pv < 0) begin
                v   = tog;
                tog = ~tog;
            end else begin
                v = ($urandom_range(99) < pv);
            end
            in_valid = v;
            in_data  = v ? q[i] : 8'($urandom);
            r        = in_ready;
            @(negedge clk);
            cyc++;
            stall = r ? 0 : stall + 1;
            if (v && r) i++;
            if (abort_after >= 0 && i == abort_after) break;
        end
        in_valid = 1'b0;
        if (must_finish) chk({nm, "_consumed"}, 64'(i), 64'(q.size()));
    endtask

    function automatic void mk_stream(output logic [7:0] q[$], input int L,
                                      input logic [31:0] words[$]);
        q.delete();
        q.push_back(8'(L >> 8));
        q.push_back(8'(L));
        foreach (words[k]) begin
            q.push_back(words[k][31:24]);
            q.push_back(words[k][23:16]);
            q.push_back(words[k][15:8]);
            q.push_back(words[k][7:0]);
        end
    endfunction

    initial begin
        logic [7:0]  q[$];
        logic [31:0] w[$];
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);

        // Reset state and first-ready timing.
        do_reset();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("rst_done",     64'(done),     64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata",    64'(mem_wdata), 64'd0);
        @(negedge clk);
        chk("first_ready",  64'(in_ready), 64'd1);

        // Two-word program with valid held high.
        q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send(q, 100, -1, 1'b1, "two_word");
        idle(3);
        chk("two_word_nwr", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("two_word_w0", wlog[0], {32'h0, 32'h11223344});
            chk("two_word_w1", wlog[1], {32'h4, 32'hAABBCCDD});
        end
        chk("two_word_done", 64'(done), 64'd1);
        chk("two_word_hold", 64'(cpu_hold), 64'd0);
        chk("model_pin_data", 64'(m_data), 64'hAABBCCDD);

        // Zero-length program.
        do_reset();
        q = '{8'h00, 8'h00};
        send(q, 100, -1, 1'b1, "zero_len");
        chk("zero_len_done", 64'(done), 64'd1);
        idle(2);
        chk("zero_len_nwr", 64'(wlog.size()), 64'd0);

        // Oversized length.
        do_reset();
        q = '{8'h01, 8'h01, 8'h12, 8'h34, 8'h56};
        send(q, 100, -1, 1'b0, "too_long");
        chk("too_long_err",   64'(error),    64'd1);
        chk("too_long_hold",  64'(cpu_hold), 64'd1);
        chk("too_long_ready", 64'(in_ready), 64'd0);
        chk("too_long_nwr",   64'(wlog.size()), 64'd0);

        // Single word with valid toggling every cycle.
        do_reset();
        q = '{8'h00, 8'h01, 8'h5A, 8'hC3, 8'h0F, 8'hF0};
        send(q, -1, -1, 1'b1, "toggle");
        idle(3);
        chk("toggle_nwr", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) chk("toggle_w0", wlog[0], {32'h0, 32'h5AC30FF0});

        // Reset in the middle of a word, then a fresh program.
        do_reset();
        q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        send(q, 100, 4, 1'b0, "abort");
        do_reset();
        q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send(q, 100, -1, 1'b1, "restart");
        idle(3);
        chk("restart_nwr", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) chk("restart_w0", wlog[0], {32'h0, 32'hDEADBEEF});

        // Extra bytes after done are ignored.
        q = '{8'hAB, 8'hCD};
        send(q, 100, -1, 1'b0, "post_done");
        chk("post_done_nwr",   64'(wlog.size()), 64'd1);
        chk("post_done_ready", 64'(in_ready), 64'd0);
        chk("post_done_addr",  64'(mem_addr), 64'd0);
        chk("post_done_data",  64'(mem_wdata), 64'hDEADBEEF);
        chk("post_done_done",  64'(done), 64'd1);

        // Full-depth program.
        do_reset();
        w.delete();
        for (int k = 0; k < DEPTH; k++) w.push_back($urandom);
        mk_stream(q, DEPTH, w);
        send(q, 100, -1, 1'b1, "full");
        idle(3);
        chk("full_nwr", 64'(wlog.size()), 64'(DEPTH));
        if (wlog.size() == DEPTH)
            chk("full_last", wlog[DEPTH-1], {32'((DEPTH-1)*4), w[DEPTH-1]});
        chk("full_done", 64'(done), 64'd1);

        // Randomized programs.
        for (int it = 0; it < 30; it++) begin
            int sel;
            int L;
            int pv;
            int nwds;
            sel  = $urandom_range(9);
            pv   = $urandom_range(30, 100);
            L    = (sel <= 6) ? sel : (sel == 7) ? DEPTH + 1 + $urandom_range(40)
                                    : (sel == 8) ? $urandom_range(65535, DEPTH + 1)
                                    : 1 + $urandom_range(5);
            nwds = (L > DEPTH) ? 2 : L;
            do_reset();
            w.delete();
            for (int k = 0; k < nwds; k++) w.push_back($urandom);
            mk_stream(q, L, w);
            if (sel == 9)
                send(q, pv, $urandom_range(1, q.size() - 1), 1'b0, "rand_abort");
            else
                send(q, pv, -1, (L <= DEPTH), "rand");
            idle($urandom_range(1, 4));
            if (sel <= 6) begin
                chk("rand_nwr", 64'(wlog.size()), 64'(L));
                foreach (wlog[k])
                    if (k < w.size()) chk("rand_word", wlog[k], {32'(k * 4), w[k]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
